// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_ibuf.sv
// One-entry instruction buffer: load, clear, or hold.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_DATA = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_data,
    output logic            o_valid,
    output logic [XLEN-1:0] o_data
);

    logic            r_valid;
    logic [XLEN-1:0] r_data;

    // Clear wins; a load is never requested while the entry is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, redirect kill, one-entry buffer to decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] PC_F,
    input  logic              PC_src,
    input  logic              stall_D,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic              stall_F,
    output logic [XLEN-1:0]   instr_F,
    output logic              instr_valid_F
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            w_ibuf_valid;
    logic [XLEN-1:0] w_ibuf_data;
    logic            w_deliver;
    logic            w_accept;
    logic            w_load;
    logic            w_clear;

    assign w_deliver = w_ibuf_valid & ~stall_D & ~PC_src;
    assign imem_req  = (r_state == IDLE) & ~w_ibuf_valid & ~PC_src;
    assign imem_addr = PC_F;
    assign w_accept  = imem_req & imem_gnt;

    // A redirect always releases the PC so the target gets loaded.
    assign stall_F = ~(w_deliver | PC_src);

    assign w_load  = (r_state == WAIT) & imem_rvalid & ~PC_src;
    assign w_clear = w_deliver | PC_src;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid)  w_state_nxt = IDLE;
                else if (PC_src)  w_state_nxt = KILL;
            end
            KILL: begin
                if (imem_rvalid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    fetch_ibuf #(
        .RESET_DATA(NOP_INSTR)
    ) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_data  (imem_rdata),
        .o_valid (w_ibuf_valid),
        .o_data  (w_ibuf_data)
    );

    assign instr_valid_F = w_ibuf_valid;
    assign instr_F       = w_ibuf_valid ? w_ibuf_data : NOP_INSTR;

endmodule
